cpu_run_ctrl: RTL and testbench

//  Synthesizable run controller and result monitor for the 5-stage pipeline CPU (CPU_pl).
//  It sequences the CPU reset, then runs the CPU until a halt self-loop (pcNext==pc) or a cycle timeout.
//  It reports cycle and halt status and an optional alu_result signature.
//  It replaces fixed-delay bench timing with a parametrised, self-terminating run, usable in sim and on FPGA.

---
 rtl/cpu_run_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller and result monitor for the CPU_pl pipeline.
// It sequences the CPU reset, runs the CPU until it sits on a halt self-loop
// (pc_next == pc repeated HALT_REPEAT times) or MAX_CYCLES elapse. Then it parks
// the CPU in reset and reports the cycle count, the halt/timeout status and an
// optional alu_result signature.
// Optional feature macro: CPU_RUN_SIG_EN (enables the alu_result signature;
// when undefined, sig is tied to zero).
// Control protocol: start is a single-cycle request, honoured only in IDLE or
// DONE; rst has priority over start in the same cycle.
module cpu_run_ctrl #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int HALT_REPEAT = 4,
    parameter int MAX_CYCLES  = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             cpu_rst,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_next,
    input  logic [WIDTH-1:0] alu_result,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [WIDTH-1:0] sig,
    output logic [1:0]       dbg_state
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int HC_W = $clog2(HALT_REPEAT + 1);
    localparam logic [RC_W-1:0]  RST_LOAD = RC_W'(RST_CYCLES);
    localparam logic [HC_W-1:0]  HALT_TGT = HC_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [HC_W-1:0]  halt_cnt_q, halt_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             halted_q, halted_d;
    logic             launch;
    logic             halt_now;
    logic             tmo_now;

    // State register and registered outputs; rst abandons any run and parks the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            halt_cnt_q <= '0;
            cnt_q      <= '0;
            cpu_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            halt_cnt_q <= halt_cnt_d;
            cnt_q      <= cnt_d;
            cpu_rst_q  <= cpu_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        halt_cnt_d = halt_cnt_q;
        cnt_d      = cnt_q;
        cpu_rst_d  = cpu_rst_q;
        running_d  = running_q;
        done_d     = done_q;
        halted_d   = halted_q;
        launch     = 1'b0;
        halt_now   = 1'b0;
        tmo_now    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // CPU stays parked; a start launches a fresh run with cleared results.
                cpu_rst_d = 1'b1;
                running_d = 1'b0;
                if (start) begin
                    launch     = 1'b1;
                    state_d    = S_RESET;
                    rst_cnt_d  = RST_LOAD;
                    halt_cnt_d = '0;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    halted_d   = 1'b0;
                end
            end
            S_RESET: begin
                // Last reset cycle drops cpu_rst and raises running on the same edge.
                cpu_rst_d = 1'b1;
                if (rst_cnt_q <= RC_W'(1)) begin
                    state_d   = S_RUN;
                    cpu_rst_d = 1'b0;
                    running_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (pc_next == pc) begin
                    halt_cnt_d = halt_cnt_q + HC_W'(1);
                end else begin
                    halt_cnt_d = '0;
                end
                halt_now = (halt_cnt_d == HALT_TGT);
                tmo_now  = (cnt_d == MAX_CNT);
                // Halt takes priority when it coincides with the timeout.
                if (halt_now || tmo_now) begin
                    state_d   = S_DONE;
                    cpu_rst_d = 1'b1;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    halted_d  = halt_now;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CPU_RUN_SIG_EN
    logic [WIDTH-1:0] sig_q, sig_d;

    // Signature: cleared at launch, rotate-left-1 then XOR alu_result every RUN cycle.
    always_comb begin
        sig_d = sig_q;
        if (launch) begin
            sig_d = '0;
        end else if (state_q == S_RUN) begin
            sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ alu_result;
        end
    end

    // Signature register; frozen outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    logic unused_alu;
    assign unused_alu = ^alu_result;
    assign sig        = '0;
`endif

    assign cpu_rst     = cpu_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl with an expected-value queue.
module tb_cpu_run_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int OBS_W = 2 + 4 + CNT_W + WIDTH;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cpu_rst;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] alu_result;
    logic             running;
    logic             done;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [WIDTH-1:0] sig;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .RST_CYCLES(2), .HALT_REPEAT(4), .MAX_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cpu_rst(cpu_rst),
        .pc(pc), .pc_next(pc_next), .alu_result(alu_result),
        .running(running), .done(done), .halted(halted),
        .cycle_count(cycle_count), .sig(sig), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [OBS_W-1:0] exp_q[$];
    string            tag_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] sig_m    = '0;
    logic [WIDTH-1:0] t5_exp [3];

    task automatic expect_obs(input string tag, input logic [1:0] st, input logic cr,
                              input logic rn, input logic dn, input logic hl,
                              input int cnt, input logic [WIDTH-1:0] sg);
        exp_q.push_back({st, cr, rn, dn, hl, CNT_W'(cnt), sg});
        tag_q.push_back(tag);
    endtask

    task automatic check_obs();
        logic [OBS_W-1:0] obs;
        logic [OBS_W-1:0] exp;
        string            tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        obs = {dbg_state, cpu_rst, running, done, halted, cycle_count, sig};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One RUN edge with the given CPU view; the signature model folds alu.
    task automatic run_cycle(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] pn,
                             input logic [WIDTH-1:0] a);
        pc         = p;
        pc_next    = pn;
        alu_result = a;
        tick();
`ifdef CPU_RUN_SIG_EN
        sig_m = {sig_m[WIDTH-2:0], sig_m[WIDTH-1]} ^ a;
`endif
    endtask

    // Start pulse, then the two reset cycles; ends with the DUT in RUN.
    task automatic launch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        sig_m = '0;
        expect_obs({tag, "_reset0"}, S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();
        tick();
        expect_obs({tag, "_reset1"}, S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();
        tick();
        expect_obs({tag, "_run0"}, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
        check_obs();
    endtask

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int edges;
`ifdef CPU_RUN_SIG_EN
        t5_exp[0] = 32'h1;
        t5_exp[1] = 32'h0;
        t5_exp[2] = 32'h3;
`else
        t5_exp[0] = 32'h0;
        t5_exp[1] = 32'h0;
        t5_exp[2] = 32'h0;
`endif
        rst        = 1'b1;
        start      = 1'b0;
        pc         = '0;
        pc_next    = '0;
        alu_result = '0;

        // T1 reset
        tick();
        tick();
        expect_obs("reset", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();
        rst = 1'b0;
        tick();
        expect_obs("idle_hold", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();

        // T2 reset sequence + T3 halt
        launch("t3");
        for (int i = 0; i < 10; i++) begin
            run_cycle(WIDTH'(4 * i), WIDTH'(4 * i + 4), $urandom);
            if (i == 0) begin
                expect_obs("t3_cnt1", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 1, sig_m);
                check_obs();
            end
        end
        expect_obs("t3_cnt10", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 10, sig_m);
        check_obs();
        edges = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            run_cycle(32'h28, 32'h28, $urandom);
            edges++;
        end
        check_int("t3_equal_cycles", edges, 4);
        expect_obs("t3_halt", S_DONE, 1'b1, 1'b0, 1'b1, 1'b1, 14, sig_m);
        check_obs();
        for (int k = 0; k < 3; k++) begin
            pc         = $urandom;
            pc_next    = $urandom;
            alu_result = $urandom;
            tick();
        end
        expect_obs("t3_frozen", S_DONE, 1'b1, 1'b0, 1'b1, 1'b1, 14, sig_m);
        check_obs();

        // T4 timeout, rerun from DONE, start ignored in RUN, short equal run
        launch("t4");
        edges = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            if (k == 5) start = 1'b1;
            if (k >= 10 && k <= 12) begin
                run_cycle(32'h100, 32'h100, $urandom);
            end else begin
                run_cycle(WIDTH'(4 * k), WIDTH'(4 * k + 4), $urandom);
            end
            start = 1'b0;
            edges = k;
            if (k == 5) begin
                expect_obs("t4_start_ignored", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 5, sig_m);
                check_obs();
            end
            if (k == 12) begin
                expect_obs("t4_three_equal", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 12, sig_m);
                check_obs();
            end
        end
        check_int("t4_run_cycles", edges, 50);
        expect_obs("t4_timeout", S_DONE, 1'b1, 1'b0, 1'b1, 1'b0, 50, sig_m);
        check_obs();

        // T6 halt and timeout on the same cycle
        launch("t6");
        edges = 0;
        for (int k = 1; k <= 60 && !done; k++) begin
            if (k <= 46) begin
                run_cycle(WIDTH'(4 * k), WIDTH'(4 * k + 4), $urandom);
            end else begin
                run_cycle(32'h200, 32'h200, $urandom);
            end
            edges = k;
        end
        check_int("t6_run_cycles", edges, 50);
        expect_obs("t6_halt_wins", S_DONE, 1'b1, 1'b0, 1'b1, 1'b1, 50, sig_m);
        check_obs();

        // T5 signature from a fresh run
        launch("t5");
        run_cycle(32'h0, 32'h4, 32'h1);
        expect_obs("t5_sig1", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 1, t5_exp[0]);
        check_obs();
        run_cycle(32'h4, 32'h8, 32'h2);
        expect_obs("t5_sig2", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 2, t5_exp[1]);
        check_obs();
        run_cycle(32'h8, 32'hc, 32'h3);
        expect_obs("t5_sig3", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, 3, t5_exp[2]);
        check_obs();
        run_cycle(32'hc, 32'h10, $urandom);
        run_cycle(32'h10, 32'h14, $urandom);

        // T6 reset mid-RUN, then rst beats start
        rst = 1'b1;
        tick();
        expect_obs("rst_mid_run", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();
        start = 1'b1;
        tick();
        expect_obs("rst_beats_start", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        expect_obs("idle_after_rst", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_obs("start_after_rst", S_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
        check_obs();

        // ---------------- final report ----------------
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
